// File: rtl/decode_skid_ctrl.sv
// Two-entry skid buffer between fetch and execute. Immediates are formed from
// inst_i on the way in and stored alongside instruction and PC.
module decode_skid_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           inst_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [31:0]           inst_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] imme_o,
    output logic [2:0]            imm_type_o,
    output logic                  illegal_o
);

    localparam logic [1:0] CNT_FULL = 2'(DEPTH);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  push, pop;

    logic [31:0]           inst_q    [2];
    logic [DATA_WIDTH-1:0] pc_q      [2];
    logic [DATA_WIDTH-1:0] imm_q     [2];
    logic [2:0]            type_q    [2];
    logic                  illegal_q [2];

    logic [DATA_WIDTH-1:0] imm_d;
    logic [2:0]            type_d;
    logic                  illegal_d;

    // ready_o depends only on registered count, so there is no ready_i -> ready_o path
    assign ready_o = (count_q != CNT_FULL);
    assign valid_o = (count_q != 2'd0);
    assign push    = valid_i & ready_o & ~flush_i;
    assign pop     = valid_o & ready_i;

    always_comb begin
        imm_d     = '0;
        type_d    = IMM_NONE;
        illegal_d = 1'b0;
        unique case (inst_i[6:0])
            7'h13, 7'h1b, 7'h03, 7'h67: begin
                type_d = IMM_I;
                imm_d  = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
            end
            7'h23: begin
                type_d = IMM_S;
                imm_d  = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            7'h63: begin
                type_d = IMM_B;
                imm_d  = {{(DATA_WIDTH-13){inst_i[31]}}, inst_i[31], inst_i[7],
                          inst_i[30:25], inst_i[11:8], 1'b0};
            end
            7'h6f: begin
                type_d = IMM_J;
                imm_d  = {{(DATA_WIDTH-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                          inst_i[20], inst_i[30:21], 1'b0};
            end
            7'h37, 7'h17: begin
                type_d = IMM_U;
                imm_d  = {{(DATA_WIDTH-32){inst_i[31]}}, inst_i[31:12], 12'b0};
            end
            7'h33, 7'h3b, 7'h73, 7'h0f: begin
                type_d = IMM_NONE;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push)
                wr_ptr_d = ~wr_ptr_q;
            if (pop)
                rd_ptr_d = ~rd_ptr_q;
            if (push && !pop)
                count_d = count_q + 2'd1;
            else if (pop && !push)
                count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                inst_q[i]    <= '0;
                pc_q[i]      <= '0;
                imm_q[i]     <= '0;
                type_q[i]    <= IMM_NONE;
                illegal_q[i] <= 1'b0;
            end
        end else if (push) begin
            inst_q[wr_ptr_q]    <= inst_i;
            pc_q[wr_ptr_q]      <= pc_i;
            imm_q[wr_ptr_q]     <= imm_d;
            type_q[wr_ptr_q]    <= type_d;
            illegal_q[wr_ptr_q] <= illegal_d;
        end
    end

    assign inst_o     = inst_q[rd_ptr_q];
    assign pc_o       = pc_q[rd_ptr_q];
    assign imme_o     = imm_q[rd_ptr_q];
    assign imm_type_o = type_q[rd_ptr_q];
    assign illegal_o  = illegal_q[rd_ptr_q];

endmodule

// File: tb/tb_decode_skid_ctrl.sv
// Directed bench for decode_skid_ctrl: immediates, ordering, back-pressure,
// flush and asynchronous reset, each against hand-computed values.
module tb_decode_skid_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] inst_i;
    logic [63:0] pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic [63:0] imme_o;
    logic [2:0]  imm_type_o;
    logic        illegal_o;

    int n_checks = 0;
    int n_errors = 0;

    decode_skid_ctrl #(.DATA_WIDTH(64), .DEPTH(2)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .inst_i     (inst_i),
        .pc_i       (pc_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .inst_o     (inst_o),
        .pc_o       (pc_o),
        .imme_o     (imme_o),
        .imm_type_o (imm_type_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] pc);
        valid_i = 1'b1;
        inst_i  = inst;
        pc_i    = pc;
    endtask

    task automatic check_head(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                              input logic [63:0] imm, input logic [2:0] typ, input logic ill);
        check({tag, ".valid"},   64'(valid_o),    64'd1);
        check({tag, ".inst"},    64'(inst_o),     64'(inst));
        check({tag, ".pc"},      pc_o,            pc);
        check({tag, ".imm"},     imme_o,          imm);
        check({tag, ".type"},    64'(imm_type_o), 64'(typ));
        check({tag, ".illegal"}, 64'(illegal_o),  64'(ill));
    endtask

    initial begin
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        inst_i  = '0;
        pc_i    = '0;
        #3;
        check("rst.valid", 64'(valid_o), 64'd0);
        check("rst.ready", 64'(ready_o), 64'd1);
        check("rst.inst",  64'(inst_o),  64'd0);
        check("rst.pc",    pc_o,         64'd0);
        check("rst.imm",   imme_o,       64'd0);
        check("rst.type",  64'(imm_type_o), 64'd0);
        check("rst.ill",   64'(illegal_o),  64'd0);
        tick();
        rst_ni = 1'b1;

        // single addi, 1-cycle latency then consumed
        ready_i = 1'b1;
        drive(32'hfff00093, 64'h8000_0000);
        tick();
        valid_i = 1'b0;
        check_head("addi", 32'hfff00093, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        tick();
        check("addi.drain", 64'(valid_o), 64'd0);

        // back-to-back U, S, J with no bubbles
        drive(32'h800002b7, 64'h100);
        tick();
        check_head("lui", 32'h800002b7, 64'h100, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        drive(32'h0020a423, 64'h104);
        tick();
        check_head("sw", 32'h0020a423, 64'h104, 64'h8, 3'd2, 1'b0);
        drive(32'h0040006f, 64'h108);
        tick();
        check_head("jal", 32'h0040006f, 64'h108, 64'h4, 3'd5, 1'b0);
        valid_i = 1'b0;
        tick();
        check("b2b.drain", 64'(valid_o), 64'd0);

        // back-pressure: A, B accepted, C held until a slot frees
        ready_i = 1'b0;
        drive(32'h00500113, 64'h200);
        tick();
        check("bp.ready1", 64'(ready_o), 64'd1);
        drive(32'h0020a423, 64'h204);
        tick();
        check("bp.full", 64'(ready_o), 64'd0);
        drive(32'h00000463, 64'h208);
        tick();
        check("bp.held", 64'(ready_o), 64'd0);
        check_head("bpA", 32'h00500113, 64'h200, 64'h5, 3'd1, 1'b0);
        ready_i = 1'b1;
        tick();
        check("bp.ready_after_pop", 64'(ready_o), 64'd1);
        check_head("bpB", 32'h0020a423, 64'h204, 64'h8, 3'd2, 1'b0);
        tick();
        valid_i = 1'b0;
        check_head("bpC", 32'h00000463, 64'h208, 64'h8, 3'd3, 1'b0);
        tick();
        check("bp.drain", 64'(valid_o), 64'd0);

        // flush while full with a pending push
        ready_i = 1'b0;
        drive(32'h00500113, 64'h300);
        tick();
        drive(32'h00600113, 64'h304);
        tick();
        check("fl.full", 64'(ready_o), 64'd0);
        flush_i = 1'b1;
        drive(32'h00900113, 64'h308);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("fl.valid", 64'(valid_o), 64'd0);
        check("fl.ready", 64'(ready_o), 64'd1);
        // flush with push from empty: push must be dropped
        flush_i = 1'b1;
        drive(32'h00a00113, 64'h30c);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("fl.push_dropped", 64'(valid_o), 64'd0);
        ready_i = 1'b1;
        drive(32'h00700193, 64'h310);
        tick();
        valid_i = 1'b0;
        check_head("fl.after", 32'h00700193, 64'h310, 64'h7, 3'd1, 1'b0);
        tick();

        // unsupported opcode followed by a legal R-type
        drive(32'h0000007f, 64'h400);
        tick();
        check_head("illegal", 32'h0000007f, 64'h400, 64'h0, 3'd0, 1'b1);
        drive(32'h00000033, 64'h404);
        tick();
        valid_i = 1'b0;
        check_head("rtype", 32'h00000033, 64'h404, 64'h0, 3'd0, 1'b0);
        tick();

        // negative B immediate: beq x0,x0,-4 = 0xfe000ee3
        drive(32'hfe000ee3, 64'h500);
        tick();
        valid_i = 1'b0;
        check_head("beq_neg", 32'hfe000ee3, 64'h500, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
        tick();

        // async reset with two entries held
        ready_i = 1'b0;
        drive(32'h00500113, 64'h600);
        tick();
        drive(32'h00600113, 64'h604);
        tick();
        valid_i = 1'b0;
        check("ar.full", 64'(ready_o), 64'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar.valid", 64'(valid_o), 64'd0);
        check("ar.ready", 64'(ready_o), 64'd1);
        check("ar.inst",  64'(inst_o),  64'd0);
        #1;
        rst_ni = 1'b1;
        ready_i = 1'b1;
        drive(32'h00b00113, 64'h700);
        tick();
        valid_i = 1'b0;
        check_head("ar.resume", 32'h00b00113, 64'h700, 64'hb, 3'd1, 1'b0);
        tick();
        check("ar.drain", 64'(valid_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_skid_ctrl.md
Name: decode_skid_ctrl

Overview:
- Two-entry skid-buffered decode-side controller between instruction fetch and execute in the RV64I core.
- Accepts fetched instruction words over a valid/ready handshake and runs each through the team's immediate generator on the input side.
- Stores instruction, PC, sign-extended immediate and an immediate-format tag per entry, and presents them in order to execute over a second valid/ready handshake.
- Handles downstream back-pressure without a combinational ready path and supports pipeline flush.

Parameters:
- DATA_WIDTH, 64, width of PC and immediate datapath.
- DEPTH, 2, buffer entries; fixed at 2 for this block.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- flush_i  input  1  discard all buffered entries (branch mispredict / trap redirect).
- valid_i  input  1  fetch presents an instruction.
- ready_o  output  1  block can accept this cycle.
- inst_i  input  32  instruction word.
- pc_i  input  DATA_WIDTH  PC of inst_i.
- valid_o  output  1  head entry valid.
- ready_i  input  1  execute consumes head this cycle.
- inst_o  output  32  head instruction.
- pc_o  output  DATA_WIDTH  head PC.
- imme_o  output  DATA_WIDTH  head sign-extended immediate.
- imm_type_o  output  3  head format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- illegal_o  output  1  head opcode not in the supported RV64I set.

Behaviour:
- Reset (rst_ni low, async): count=0, read/write pointers=0, all storage cleared.
  - Outputs during reset: valid_o=0, inst_o=0, pc_o=0, imme_o=0, imm_type_o=0, illegal_o=0, ready_o=1.
- Handshakes:
  - push = valid_i & ready_o & ~flush_i.
  - pop = valid_o & ready_i.
  - ready_o = (count != 2), derived from registered count only; there is no path from ready_i to ready_o.
  - valid_o = (count != 0).
  - All head outputs are driven from storage, never directly from inst_i.
- Latency: an instruction pushed at edge N appears on valid_o/outputs after edge N; minimum latency 1 cycle.
- Immediate formation is combinational on inst_i, captured at push. Opcode decode of inst_i[6:0]:
  - 0x13, 0x1b, 0x03, 0x67: I, imm = sext(inst[31:20]).
  - 0x23: S, imm = sext({inst[31:25], inst[11:7]}).
  - 0x63: B, imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - 0x6f: J, imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - 0x37, 0x17: U, imm = sext32({inst[31:12], 12'b0}).
  - 0x33, 0x3b, 0x73, 0x0f: NONE, imm = 0, illegal = 0.
  - Any other opcode: NONE, imm = 0, illegal = 1.
- Count update:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - Both: count unchanged, both pointers advance.
- Pointers: 1-bit, wrap 1→0.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Full (count=2): ready_o=0; valid_i is ignored and fetch must hold its data.
  - A pop at count=2 frees an entry that is visible on ready_o the next cycle, not the same cycle.
- Empty (count=0): valid_o=0. A pop is impossible; a push proceeds normally.
- Flush:
  - On the edge where flush_i=1: count←0, pointers←0.
  - Any same-cycle push is discarded.
  - A same-cycle pop is still a legal consumption downstream; the buffer simply ends empty.
  - Next cycle: valid_o=0, ready_o=1.
- Head outputs while valid_o=0 hold their last values; downstream must not sample them.
- An async reset mid-transfer drops all entries immediately, without waiting for a clock edge.

Test Plan:
- Reset then push 0xfff00093 (addi x1,x0,-1) with pc 0x80000000, ready_i=1 → next cycle valid_o=1, imme_o=0xFFFFFFFFFFFFFFFF, imm_type_o=1, pc_o=0x80000000; the cycle after, valid_o=0.
- Push 0x800002b7 (lui), 0x0020a423 (sw x2,8(x1)), 0x0040006f (jal +4) back-to-back with ready_i=1 → imme_o sequence 0xFFFFFFFF80000000/U, 0x8/S, 0x4/J, one per cycle, no bubbles after the first.
- ready_i=0 and push 3 instructions → ready_o drops to 0 after 2 accepts and the third is held. Then ready_i=1 → order A,B,C delivered, and C is accepted exactly one cycle after the first pop.
- Fill to count=2, assert flush_i with valid_i=1 → no entry accepted; next cycle valid_o=0, ready_o=1; subsequent push delivered normally.
- Push 0x0000007f (unsupported opcode) → illegal_o=1, imm_type_o=0, imme_o=0. Push 0x00000033 → illegal_o=0, imm_type_o=0.
- With count=2, drive rst_ni low between clock edges → valid_o=0 and ready_o=1 immediately, before the next edge; after release the buffer resumes from empty.
